fft_16_frame_unpacker: RTL and testbench

//  Receiver for the 4-lane FFT output interface: captures one 16-point complex frame (4 beats x 4 lanes,

---
 rtl/fft_16_frame_unpacker.sv | 265 ++++++++++++++++++++++++++
 tb/tb_fft_16_frame_unpacker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_16_frame_unpacker.sv
// fft_16_frame_unpacker
// Captures 16-point complex frames from the 4-lane FFT output (4 beats x 4 lanes)
// into a two-bank ping-pong buffer and replays each frame as a serial valid/ready
// stream with sample index and last markers. Full buffers drop whole frames,
// because the FFT upstream cannot be stalled.
// Optional build macro: FFT_UNPACK_BITREV_EN -- replay frames in bit-reversed
// address order, so a bit-reversed FFT output leaves here in natural order.
module fft_16_frame_unpacker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] x_a_in,
    input  logic [DATA_W-1:0] x_b_in,
    input  logic [DATA_W-1:0] x_c_in,
    input  logic [DATA_W-1:0] x_d_in,
    input  logic [DATA_W-1:0] y_a_in,
    input  logic [DATA_W-1:0] y_b_in,
    input  logic [DATA_W-1:0] y_c_in,
    input  logic [DATA_W-1:0] y_d_in,
    input  logic              ctrl_in,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [3:0]        idx_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              last_out,
    output logic              overflow_out,
    output logic              frame_err_out
);

    localparam int SW = 2 * DATA_W;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_t;
    typedef enum logic {W_IDLE, W_FILL} w_st_t;
    typedef enum logic {R_IDLE, R_SEND} r_st_t;

    // Replay address for output sample n.
    function automatic logic [3:0] rd_map(input logic [3:0] n);
`ifdef FFT_UNPACK_BITREV_EN
        return {n[0], n[1], n[2], n[3]};
`else
        return n;
`endif
    endfunction

    // Write side state
    w_st_t       w_state_q, w_state_d;
    logic [1:0]  beat_q, beat_d;
    logic        w_bank_q, w_bank_d;
    bank_st_t    bank_st_q [2];
    bank_st_t    bank_st_d [2];

    // Read side state and output register
    r_st_t       r_state_q, r_state_d;
    logic        r_bank_q, r_bank_d;
    logic [3:0]  idx_q, idx_d;
    logic        last_q, last_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d;

    // Control between the two sides
    logic        wr_en;
    logic        wr_bank;
    logic [1:0]  wr_beat;
    logic        release_en;
    logic        ld_en;
    logic        ld_bank;
    logic [3:0]  ld_n;
    logic        go_idle;
    logic [1:0]  free_now;
    logic        overflow;
    logic        frame_err;

    // Buffer read path
    logic [SW-1:0] lane_wdata [4];
    logic [SW-1:0] lane_rd    [4];
    logic [3:0]    rd_k;
    logic [2:0]    rd_row;
    logic [SW-1:0] rd_word;

    assign lane_wdata[0] = {x_a_in, y_a_in};
    assign lane_wdata[1] = {x_b_in, y_b_in};
    assign lane_wdata[2] = {x_c_in, y_c_in};
    assign lane_wdata[3] = {x_d_in, y_d_in};

    assign rd_k   = rd_map(ld_n);
    assign rd_row = {ld_bank, rd_k[3:2]};

    // One small memory per lane, row = {bank, beat}; a whole beat lands in one cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [SW-1:0] mem_q [8];

        // Lane storage write; contents need no reset since bank state gates reads.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[{wr_bank, wr_beat}] <= lane_wdata[gi];
            end
        end

        assign lane_rd[gi] = mem_q[rd_row];
    end

    // A bank counts as free if empty, or if its last sample is handed off this cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_free
        assign free_now[gi] = (bank_st_q[gi] == B_EMPTY) ||
                              (release_en && (r_bank_q == 1'(gi)));
    end

    // Read FSM: choose the bank to replay and the next sample to load.
    always_comb begin
        r_state_d  = r_state_q;
        r_bank_d   = r_bank_q;
        idx_d      = idx_q;
        last_d     = last_q;
        ld_en      = 1'b0;
        ld_bank    = r_bank_q;
        ld_n       = 4'd0;
        release_en = 1'b0;
        go_idle    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                // At most one bank can be FULL while idle; lower index wins a tie.
                if (bank_st_q[0] == B_FULL) begin
                    ld_en   = 1'b1;
                    ld_bank = 1'b0;
                end else if (bank_st_q[1] == B_FULL) begin
                    ld_en   = 1'b1;
                    ld_bank = 1'b1;
                end
                if (ld_en) begin
                    r_state_d = R_SEND;
                    r_bank_d  = ld_bank;
                    idx_d     = 4'd0;
                    last_d    = 1'b0;
                end
            end
            R_SEND: begin
                if (ready_in) begin
                    if (idx_q == 4'd15) begin
                        release_en = 1'b1;
                        // The other bank, if FULL, is necessarily the next-oldest frame.
                        if (bank_st_q[~r_bank_q] == B_FULL) begin
                            ld_en    = 1'b1;
                            ld_bank  = ~r_bank_q;
                            r_bank_d = ~r_bank_q;
                        end else begin
                            r_state_d = R_IDLE;
                            go_idle   = 1'b1;
                        end
                        idx_d  = 4'd0;
                        last_d = 1'b0;
                    end else begin
                        ld_en  = 1'b1;
                        ld_n   = idx_q + 4'd1;
                        idx_d  = ld_n;
                        last_d = (ld_n == 4'd15);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Output data register: load a new sample, clear when going idle, else hold.
    always_comb begin
        rd_word = lane_rd[rd_k[1:0]];
        x_d     = x_q;
        y_d     = y_q;
        if (ld_en) begin
            x_d = rd_word[SW-1:DATA_W];
            y_d = rd_word[DATA_W-1:0];
        end else if (go_idle) begin
            x_d = '0;
            y_d = '0;
        end
    end

    // Write FSM and bank bookkeeping.
    always_comb begin
        w_state_d = w_state_q;
        beat_d    = beat_q;
        w_bank_d  = w_bank_q;
        bank_st_d = bank_st_q;
        wr_en     = 1'b0;
        wr_bank   = w_bank_q;
        wr_beat   = beat_q;
        overflow  = 1'b0;
        frame_err = 1'b0;
        if (release_en) begin
            bank_st_d[r_bank_q] = B_EMPTY;
        end
        case (w_state_q)
            W_IDLE: begin
                if (ctrl_in) begin
                    if (free_now[0] || free_now[1]) begin
                        wr_bank   = free_now[0] ? 1'b0 : 1'b1;
                        w_bank_d  = wr_bank;
                        wr_en     = 1'b1;
                        wr_beat   = 2'd0;
                        beat_d    = 2'd1;
                        w_state_d = W_FILL;
                        bank_st_d[wr_bank] = B_FILLING;
                    end else begin
                        overflow = 1'b1;
                    end
                end
            end
            W_FILL: begin
                wr_en = 1'b1;
                if (ctrl_in) begin
                    // A new frame start mid-frame: abandon the partial frame, reuse the bank.
                    frame_err = 1'b1;
                    wr_beat   = 2'd0;
                    beat_d    = 2'd1;
                end else begin
                    wr_beat = beat_q;
                    beat_d  = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        bank_st_d[w_bank_q] = B_FULL;
                        w_state_d           = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            w_state_q <= W_IDLE;
            beat_q    <= 2'd0;
            w_bank_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                bank_st_q[i] <= B_EMPTY;
            end
            r_state_q <= R_IDLE;
            r_bank_q  <= 1'b0;
            idx_q     <= 4'd0;
            last_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            w_state_q <= w_state_d;
            beat_q    <= beat_d;
            w_bank_q  <= w_bank_d;
            bank_st_q <= bank_st_d;
            r_state_q <= r_state_d;
            r_bank_q  <= r_bank_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign idx_out       = idx_q;
    assign last_out      = last_q;
    assign valid_out     = (r_state_q == R_SEND);
    assign overflow_out  = overflow;
    assign frame_err_out = frame_err;

endmodule

// File: tb/tb_fft_16_frame_unpacker.sv
// Testbench for fft_16_frame_unpacker: directed frames, expected samples queued
// at issue time, a negedge monitor pops and compares on every handshake.
module tb_fft_16_frame_unpacker;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_in;
    logic [DATA_W-1:0] x_a_in, x_b_in, x_c_in, x_d_in;
    logic [DATA_W-1:0] y_a_in, y_b_in, y_c_in, y_d_in;
    logic              ctrl_in;
    logic [DATA_W-1:0] x_out, y_out;
    logic [3:0]        idx_out;
    logic              valid_out;
    logic              ready_in;
    logic              last_out;
    logic              overflow_out;
    logic              frame_err_out;

    fft_16_frame_unpacker #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .x_a_in       (x_a_in),
        .x_b_in       (x_b_in),
        .x_c_in       (x_c_in),
        .x_d_in       (x_d_in),
        .y_a_in       (y_a_in),
        .y_b_in       (y_b_in),
        .y_c_in       (y_c_in),
        .y_d_in       (y_d_in),
        .ctrl_in      (ctrl_in),
        .x_out        (x_out),
        .y_out        (y_out),
        .idx_out      (idx_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .last_out     (last_out),
        .overflow_out (overflow_out),
        .frame_err_out(frame_err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] idx;
        logic       last;
    } smp_t;

    smp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;    // 0: always ready, 1: toggle each cycle, 2: never ready
    logic exp_ovf = 1'b0;
    logic exp_ferr = 1'b0;
    int   frame_cyc = 0;
    int   last_pop_cyc = 0;
    logic hold_v = 1'b0;
    smp_t hold_s;
    int   br_tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_in  = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        x_a_in = 8'hEE; x_b_in = 8'hEE; x_c_in = 8'hEE; x_d_in = 8'hEE;
        y_a_in = 8'hEE; y_b_in = 8'hEE; y_c_in = 8'hEE; y_d_in = 8'hEE;
    endtask

    // Lane l of beat b carries x = base + 4b + l, y = yv.
    task automatic drive_beat(input logic c, input logic [7:0] base, input logic [7:0] yv, input int b);
        ctrl_in = c;
        x_a_in = base + 8'(4 * b + 0);
        x_b_in = base + 8'(4 * b + 1);
        x_c_in = base + 8'(4 * b + 2);
        x_d_in = base + 8'(4 * b + 3);
        y_a_in = yv; y_b_in = yv; y_c_in = yv; y_d_in = yv;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] yv, input logic ovf);
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b == 0) frame_cyc = cyc;
            exp_ovf = ovf && (b == 0);
            drive_beat(b == 0, base, yv, b);
        end
    endtask

    task automatic push_frame(input logic [7:0] base, input logic [7:0] yv);
        smp_t s;
        for (int n = 0; n < 16; n++) begin
`ifdef FFT_UNPACK_BITREV_EN
            s.x = base + 8'(br_tbl[n]);
`else
            s.x = base + 8'(n);
`endif
            s.y    = yv;
            s.idx  = 4'(n);
            s.last = (n == 15);
            exp_q.push_back(s);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk({nm, "_drained_remaining"}, exp_q.size(), 0);
        repeat (30) tick();
    endtask

    // Ready pattern generator
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: ready_in = 1'b1;
                1: ready_in = ~ready_in;
                default: ready_in = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and pulses.
    always @(negedge clk) begin
        if (rst_in) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!valid_out || x_out !== hold_s.x || y_out !== hold_s.y ||
                    idx_out !== hold_s.idx || last_out !== hold_s.last) begin
                    failures++;
                    $display("FAIL stall_hold got v=%0b x=%0d y=%0d idx=%0d last=%0b want v=1 x=%0d y=%0d idx=%0d last=%0b",
                             valid_out, x_out, y_out, idx_out, last_out,
                             hold_s.x, hold_s.y, hold_s.idx, hold_s.last);
                end
            end
            hold_v = 1'b0;
            if (valid_out) begin
                if (!ready_in) begin
                    hold_v = 1'b1;
                    hold_s = '{x: x_out, y: y_out, idx: idx_out, last: last_out};
                end else begin
                    checks++;
                    last_pop_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_sample got x=%0d y=%0d idx=%0d want no sample (cycle %0d)",
                                 x_out, y_out, idx_out, cyc);
                    end else begin
                        smp_t e;
                        e = exp_q.pop_front();
                        if (x_out !== e.x || y_out !== e.y || idx_out !== e.idx || last_out !== e.last) begin
                            failures++;
                            $display("FAIL sample got x=%0d y=%0d idx=%0d last=%0b want x=%0d y=%0d idx=%0d last=%0b",
                                     x_out, y_out, idx_out, last_out, e.x, e.y, e.idx, e.last);
                        end
                    end
                end
            end
            if (exp_ovf || overflow_out) begin
                checks++;
                if (overflow_out !== exp_ovf) begin
                    failures++;
                    $display("FAIL overflow_pulse got=%0b want=%0b (cycle %0d)", overflow_out, exp_ovf, cyc);
                end
            end
            if (exp_ferr || frame_err_out) begin
                checks++;
                if (frame_err_out !== exp_ferr) begin
                    failures++;
                    $display("FAIL frame_err_pulse got=%0b want=%0b (cycle %0d)", frame_err_out, exp_ferr, cyc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start;
        int seen;
        rst_in = 1'b1;
        ctrl_in = 1'b0;
        x_a_in = '0; x_b_in = '0; x_c_in = '0; x_d_in = '0;
        y_a_in = '0; y_b_in = '0; y_c_in = '0; y_d_in = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", valid_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_idx", idx_out, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_overflow", overflow_out, 0);
        chk("rst_frame_err", frame_err_out, 0);
        rst_in = 1'b0;
        idle_inputs();
        repeat (3) tick();
        $display("reset check done");

        // Test 1: ramp frame, always ready, latency and burst length
        ready_mode = 0;
        push_frame(8'h00, 8'h00);
        send_frame(8'h00, 8'h00, 1'b0);
        tick();
        idle_inputs();
        n = 0;
        while (!valid_out && n < 20) begin
            tick();
            n++;
        end
        chk("t1_first_valid_cycle", cyc, frame_cyc + 5);
        start = cyc;
        drain("t1");
        chk("t1_burst_span", last_pop_cyc - start, 15);
        $display("test1 ramp frame done");

        // Test 2: toggling ready, stable while stalled
        ready_mode = 1;
        push_frame(8'h40, 8'h05);
        send_frame(8'h40, 8'h05, 1'b0);
        tick();
        idle_inputs();
        drain("t2");
        ready_mode = 0;
        $display("test2 backpressure frame done");

        // Test 3: three back-to-back frames with no ready -> third dropped
        ready_mode = 2;
        push_frame(8'h00, 8'h01);
        push_frame(8'h40, 8'h02);
        send_frame(8'h00, 8'h01, 1'b0);
        send_frame(8'h40, 8'h02, 1'b0);
        send_frame(8'h80, 8'h03, 1'b1);
        tick();
        idle_inputs();
        repeat (20) tick();
        ready_mode = 0;
        drain("t3");
        $display("test3 overflow frames done");

        // Test 4: restart mid-frame at beat 2
        push_frame(8'h20, 8'h04);
        tick(); drive_beat(1'b1, 8'h10, 8'h09, 0);
        tick(); drive_beat(1'b0, 8'h10, 8'h09, 1);
        tick(); exp_ferr = 1'b1; drive_beat(1'b1, 8'h20, 8'h04, 0);
        tick(); exp_ferr = 1'b0; drive_beat(1'b0, 8'h20, 8'h04, 1);
        tick(); drive_beat(1'b0, 8'h20, 8'h04, 2);
        tick(); drive_beat(1'b0, 8'h20, 8'h04, 3);
        tick();
        idle_inputs();
        drain("t4");
        $display("test4 frame error restart done");

        // Test 6: reset while idx 7 is presented
        push_frame(8'h60, 8'h06);
        send_frame(8'h60, 8'h06, 1'b0);
        tick();
        idle_inputs();
        n = 0;
        while (!(valid_out && idx_out == 4'd7) && n < 60) begin
            tick();
            n++;
        end
        chk("t6_reached_idx7", idx_out, 7);
        #1;
        rst_in = 1'b1;
        #1;
        chk("t6_valid_drop_async", valid_out, 0);
        exp_q.delete();
        tick();
        tick();
        rst_in = 1'b0;
        seen = 0;
        repeat (30) begin
            tick();
            if (valid_out) seen++;
        end
        chk("t6_quiet_after_reset", seen, 0);
        push_frame(8'h70, 8'h07);
        send_frame(8'h70, 8'h07, 1'b0);
        tick();
        idle_inputs();
        drain("t6_recover");
        $display("test6 reset mid-frame done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
